// File: rtl/ft64_copper_list_ram_if.sv
// ft64_copper_list_ram_if: Wishbone-classic 64-bit bus between the copper master and its list RAM.
// Signals: cs_i/cyc_i/stb_i/we_i request qualifiers, sel_i byte lanes, adr_i byte address,
// dat_i write data, ack_o/err_o terminations, dat_o read data.
interface ft64_copper_list_ram_if #(
  parameter int AW = 32
);
  logic          cs_i;
  logic          cyc_i;
  logic          stb_i;
  logic          we_i;
  logic [7:0]    sel_i;
  logic [AW-1:0] adr_i;
  logic [63:0]   dat_i;
  logic          ack_o;
  logic          err_o;
  logic [63:0]   dat_o;
  modport master (output cs_i, cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, input ack_o, err_o, dat_o);
  modport slave  (input cs_i, cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, output ack_o, err_o, dat_o);
endinterface

// File: rtl/ft64_copper_list_ram.sv
// ft64_copper_list_ram: copper display-list RAM, Wishbone slave with wait states and range error.
// Ports: clk_i bus clock, rst_ni async active-low reset, bus slave modport of ft64_copper_list_ram_if.
module ft64_copper_list_ram #(
  parameter int            AW         = 32,
  parameter int            DEPTH_LOG2 = 10,
  parameter logic [AW-1:0] BASE       = 'hFFD8_0000,
  parameter int            RD_LAT     = 2,
  parameter int            WR_LAT     = 1
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  ft64_copper_list_ram_if.slave bus
);
  localparam int HI = DEPTH_LOG2 + 3;
  localparam logic [2:0] RD_C = 3'(RD_LAT - 1);
  localparam logic [2:0] WR_C = 3'(WR_LAT - 1);
  typedef enum logic [2:0] {IDLE, LAT, ACK, ERR, HOLD} state_t;
  state_t                state;
  logic [2:0]            cnt;
  logic                  q_we;
  logic [7:0]            q_sel;
  logic [DEPTH_LOG2-1:0] q_idx;
  logic [63:0]           q_dat;
  logic [63:0]           ram [2**DEPTH_LOG2];
  logic                  live, req, hit, lat0, start, fire, a_we;
  logic [7:0]            a_sel;
  logic [DEPTH_LOG2-1:0] a_idx;
  logic [63:0]           a_dat;
  assign live  = bus.cyc_i & bus.stb_i;
  assign req   = bus.cs_i & live;
  assign hit   = bus.adr_i[AW-1:HI] == BASE[AW-1:HI];
  assign lat0  = bus.we_i ? WR_C == 3'd0 : RD_C == 3'd0;
  assign start = state == IDLE & req & hit;
  // Zero-wait accesses happen at the sampling edge, so they use the live bus instead of the capture.
  assign fire  = rst_ni & ((start & lat0) | (state == LAT & live & cnt == 3'd1));
  assign a_we  = state == IDLE ? bus.we_i : q_we;
  assign a_sel = state == IDLE ? bus.sel_i : q_sel;
  assign a_idx = state == IDLE ? bus.adr_i[HI-1:3] : q_idx;
  assign a_dat = state == IDLE ? bus.dat_i : q_dat;
  always_ff @(posedge clk_i)
    if (fire & a_we)
      for (int i = 0; i < 8; i++)
        if (a_sel[i]) ram[a_idx][8*i +: 8] <= a_dat[8*i +: 8];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      q_we      <= 1'b0;
      q_sel     <= 8'd0;
      q_idx     <= '0;
      q_dat     <= 64'd0;
      bus.ack_o <= 1'b0;
      bus.err_o <= 1'b0;
      bus.dat_o <= 64'd0;
    end else begin
      if (fire & ~a_we) bus.dat_o <= ram[a_idx];
      case (state)
        IDLE:
          if (req & ~hit) begin
            state     <= ERR;
            bus.err_o <= 1'b1;
          end else if (start) begin
            q_we      <= bus.we_i;
            q_sel     <= bus.sel_i;
            q_idx     <= bus.adr_i[HI-1:3];
            q_dat     <= bus.dat_i;
            cnt       <= bus.we_i ? WR_C : RD_C;
            state     <= lat0 ? ACK : LAT;
            bus.ack_o <= lat0;
          end
        LAT:
          if (!live) state <= IDLE;
          else begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) begin
              state     <= ACK;
              bus.ack_o <= 1'b1;
            end
          end
        ACK, ERR:
          if (!live) begin
            state     <= HOLD;
            bus.ack_o <= 1'b0;
            bus.err_o <= 1'b0;
          end
        HOLD: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ft64_copper_list_ram.sv
// tb_ft64_copper_list_ram: directed and random checks of two list RAMs (RD/WR latency 2/1 and 4/4) against a word-array model.
module tb_ft64_copper_list_ram;
  localparam logic [31:0] BASE = 32'hFFD8_0000;
  logic        clk = 1'b0;
  logic        rst_n, cs, cyc, stb, we, use_b;
  logic [7:0]  sel;
  logic [31:0] adr;
  logic [63:0] dat;
  logic        ack, err;
  logic [63:0] dout;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] mem_a [int];
  logic [63:0] mem_b [int];
  int          pool [8];
  always #5 clk = ~clk;
  ft64_copper_list_ram_if #(.AW(32)) ia ();
  ft64_copper_list_ram_if #(.AW(32)) ib ();
  assign ia.cs_i  = cs;
  assign ia.cyc_i = cyc & ~use_b;
  assign ia.stb_i = stb & ~use_b;
  assign ia.we_i  = we;
  assign ia.sel_i = sel;
  assign ia.adr_i = adr;
  assign ia.dat_i = dat;
  assign ib.cs_i  = cs;
  assign ib.cyc_i = cyc & use_b;
  assign ib.stb_i = stb & use_b;
  assign ib.we_i  = we;
  assign ib.sel_i = sel;
  assign ib.adr_i = adr;
  assign ib.dat_i = dat;
  assign ack  = use_b ? ib.ack_o : ia.ack_o;
  assign err  = use_b ? ib.err_o : ia.err_o;
  assign dout = use_b ? ib.dat_o : ia.dat_o;
  ft64_copper_list_ram #(.RD_LAT(2), .WR_LAT(1)) ua (.clk_i(clk), .rst_ni(rst_n), .bus(ia));
  ft64_copper_list_ram #(.RD_LAT(4), .WR_LAT(4)) ub (.clk_i(clk), .rst_ni(rst_n), .bus(ib));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] model_rd(input int i);
    if (use_b) return mem_b.exists(i) ? mem_b[i] : 64'hx;
    return mem_a.exists(i) ? mem_a[i] : 64'hx;
  endfunction
  task automatic model_wr(input int i, input logic [7:0] s, input logic [63:0] d);
    logic [63:0] w;
    w = model_rd(i);
    for (int l = 0; l < 8; l++) if (s[l]) w[8*l +: 8] = d[8*l +: 8];
    if (use_b) mem_b[i] = w; else mem_a[i] = w;
  endtask
  task automatic xfer(input bit w, input logic [31:0] a, input logic [7:0] s, input logic [63:0] d,
                      input int extra, input bit keep_cyc, input bit tail);
    int n, lat, idx;
    bit inr;
    logic [63:0] old;
    lat = use_b ? 4 : (w ? 1 : 2);
    inr = a[31:13] == BASE[31:13];
    idx = int'(a[12:3]);
    @(negedge clk);
    cs = 1'b1; cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d;
    old = dout;
    n = 0;
    while (!(ack | err) && n < 20) begin
      @(posedge clk); #1;
      n++;
      chk("excl", {63'd0, ack & err}, 64'd0);
    end
    chk("latency", 64'(n), 64'((inr ? lat : 1) + extra));
    chk("ack", {63'd0, ack}, {63'd0, inr});
    chk("err", {63'd0, err}, {63'd0, ~inr});
    if (!inr) chk("err_dat", dout, old);
    else if (w) begin
      chk("wr_dat", dout, old);
      model_wr(idx, s, d);
    end else chk("rd_dat", dout, model_rd(idx));
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
      chk("hold", {63'd0, ack | err}, 64'd1);
    end
    @(negedge clk);
    stb = 1'b0;
    if (!keep_cyc) begin cyc = 1'b0; cs = 1'b0; end
    @(posedge clk); #1;
    chk("drop", {62'd0, ack, err}, 64'd0);
    if (tail) @(posedge clk);
  endtask
  task automatic abort(input bit w, input logic [31:0] a, input logic [63:0] d);
    logic [63:0] old;
    @(negedge clk);
    cs = 1'b1; cyc = 1'b1; stb = 1'b1; we = w; sel = 8'hFF; adr = a; dat = d;
    old = dout;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_early", {63'd0, ack}, 64'd0);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; cs = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort_quiet", {62'd0, ack, err}, 64'd0);
    end
    chk("abort_dat", dout, old);
  endtask
  task automatic rand_ops(input int count);
    for (int k = 0; k < 8; k++) begin
      pool[k] = int'($urandom_range(0, 1023));
      xfer(1'b1, BASE + 32'(pool[k] * 8), 8'hFF, {$urandom, $urandom}, 0, 1'b0, 1'b1);
    end
    for (int k = 0; k < count; k++)
      xfer(1'($urandom), BASE + 32'(pool[$urandom_range(0, 7)] * 8), 8'($urandom),
           {$urandom, $urandom}, 0, 1'b0, 1'b1);
  endtask
  initial begin
    rst_n = 1'b0; use_b = 1'b0;
    cs = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 8'd0; adr = 32'd0; dat = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", {ia.ack_o, ia.err_o, 62'd0}, 64'd0);
    chk("rst_a_dat", ia.dat_o, 64'd0);
    chk("rst_b", {ib.ack_o, ib.err_o, 62'd0}, 64'd0);
    chk("rst_b_dat", ib.dat_o, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    xfer(1'b1, BASE + 32'h10, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 1'b1);
    xfer(1'b0, BASE + 32'h10, 8'hFF, 64'd0, 0, 1'b0, 1'b1);
    chk("wr_rd", dout, 64'h0123_4567_89AB_CDEF);
    xfer(1'b1, BASE + 32'h28, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 1'b1);
    xfer(1'b1, BASE + 32'h28, 8'h0F, 64'd0, 0, 1'b0, 1'b1);
    xfer(1'b0, BASE + 32'h28, 8'hFF, 64'd0, 0, 1'b0, 1'b1);
    chk("lanes", dout, 64'hFFFF_FFFF_0000_0000);
    xfer(1'b1, BASE + 32'h28, 8'h00, 64'h1234_5678_9ABC_DEF0, 0, 1'b0, 1'b1);
    xfer(1'b0, BASE + 32'h28, 8'hFF, 64'd0, 0, 1'b0, 1'b1);
    chk("sel_zero", dout, 64'hFFFF_FFFF_0000_0000);
    xfer(1'b1, BASE, 8'hFF, {$urandom, $urandom}, 0, 1'b0, 1'b1);
    xfer(1'b1, BASE + 32'h8, 8'hFF, {$urandom, $urandom}, 0, 1'b0, 1'b1);
    xfer(1'b0, BASE, 8'hFF, 64'd0, 0, 1'b1, 1'b0);
    xfer(1'b0, BASE + 32'h8, 8'hFF, 64'd0, 1, 1'b0, 1'b1);
    xfer(1'b0, BASE + 32'h2000, 8'hFF, 64'd0, 0, 1'b0, 1'b1);
    xfer(1'b1, BASE - 32'h8, 8'hFF, 64'hDEAD, 0, 1'b0, 1'b1);
    xfer(1'b0, BASE - 32'h8, 8'hFF, 64'd0, 0, 1'b0, 1'b1);
    rand_ops(30);
    use_b = 1'b1;
    xfer(1'b1, BASE + 32'h40, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0, 0, 1'b0, 1'b1);
    abort(1'b0, BASE + 32'h40, 64'd0);
    xfer(1'b0, BASE + 32'h40, 8'hFF, 64'd0, 0, 1'b0, 1'b1);
    abort(1'b1, BASE + 32'h40, 64'h1111_2222_3333_4444);
    xfer(1'b0, BASE + 32'h40, 8'hFF, 64'd0, 0, 1'b0, 1'b1);
    chk("abort_wr", dout, 64'hA5A5_5A5A_0F0F_F0F0);
    rand_ops(15);
    use_b = 1'b0;
    @(negedge clk);
    cs = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 8'hFF; adr = BASE + 32'h10;
    for (int n = 0; n < 20 && !ack; n++) @(posedge clk);
    #1;
    chk("pre_rst_ack", {63'd0, ack}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {62'd0, ack, err}, 64'd0);
    chk("async_rst_dat", dout, 64'd0);
    @(negedge clk);
    cs = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    xfer(1'b0, BASE + 32'h10, 8'hFF, 64'd0, 0, 1'b0, 1'b1);
    chk("post_rst", dout, 64'h0123_4567_89AB_CDEF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ft64_copper_list_ram.md
Name: ft64_copper_list_ram

Overview:
- Wishbone-classic 64-bit slave memory holding copper display lists.
- The copper master fetches 128-bit instructions as two consecutive 64-bit reads, holding cyc high and toggling stb between them; it also issues MOVE writes.
- This block is the responder end of that bus. It provides registered reads with programmable wait states, byte-lane writes, error response on out-of-range addresses, and a strict stb/ack four-phase handshake.

Parameters:
- AW, 32: address width.
- DEPTH_LOG2, 10: log2 of the number of 64-bit words (1024 words = 8 KiB).
- BASE, 32'hFFD8_0000: byte base address, aligned to 2^(DEPTH_LOG2+3).
- RD_LAT, 2: read latency in clocks, from strobe sample to ack; legal range 1..7.
- WR_LAT, 1: write latency in clocks, legal range 1..7.

Ports:
- clk_i  in  1  bus clock.
- rst_ni  in  1  asynchronous active-low reset.
- cs_i  in  1  circuit select from the system decoder.
- cyc_i  in  1  bus cycle valid.
- stb_i  in  1  strobe.
- we_i  in  1  1 = write.
- sel_i  in  8  byte-lane enables.
- adr_i  in  AW  byte address; bits [2:0] ignored.
- dat_i  in  64  write data.
- ack_o  out  1  transfer acknowledge.
- err_o  out  1  error acknowledge (address out of range).
- dat_o  out  64  read data, registered.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - ack_o=0, err_o=0, dat_o=0, state=IDLE, latency counter=0.
  - RAM contents are not cleared.
- Decode:
  - req = cs_i & cyc_i & stb_i.
  - hit = adr_i[AW-1:DEPTH_LOG2+3] == BASE[AW-1:DEPTH_LOG2+3].
  - Word index = adr_i[DEPTH_LOG2+2:3].
- State machine (IDLE, LAT, ACK, ERR, HOLD):
  - IDLE:
    - req & ~hit -> ERR, err_o<=1 at the same edge (1-cycle latency). No RAM access.
    - req & hit -> capture we_i, sel_i, index, dat_i; load counter with (we ? WR_LAT : RD_LAT) - 1.
    - If the counter value is 0, perform the access and go to ACK with ack_o<=1; otherwise go to LAT.
  - LAT:
    - Counter decrements each clock.
    - When counter==1 at an edge, perform the access and set ack_o<=1 at that edge; go to ACK.
    - Net effect: ack_o first seen high exactly LAT clocks after the edge that sampled req.
  - Access rules:
    - Read: dat_o <= RAM[index], updated at the ack edge.
    - Write: for each lane i with sel[i]=1, RAM[index][8i+7:8i] <= dat[8i+7:8i], committed at the ack edge. dat_o is unchanged.
    - Write with sel=8'h00: acked, no RAM change.
  - ACK / ERR:
    - ack_o (or err_o) holds high while stb_i stays high.
    - At the first edge with stb_i=0 or cyc_i=0: drop ack_o/err_o and go to HOLD.
  - HOLD:
    - One dead cycle, then IDLE.
    - A new strobe is not sampled until IDLE. Back-to-back fetches therefore see at least 2 idle clocks between ack fall and the next ack rise.
- Abort: cyc_i or stb_i low during LAT -> return to IDLE. No write is committed, dat_o is unchanged, ack_o is never raised.
- Captured request: address and data are captured in IDLE. Changes on adr_i/dat_i during LAT are ignored.
- Ordering: a read issued after a write's ack returns the written data (no bypass hazard). The write commits before the read's latency begins.
- cs_i dropping mid-transfer is ignored; cyc_i/stb_i govern.
- ack_o and err_o are never high simultaneously. Neither is asserted without a sampled request.
- Asynchronous reset mid-transfer forces IDLE immediately. A pending write is discarded.

Test Plan:
- Write then read:
  - Write adr=BASE+8'h10, sel=FF, dat=64'h0123_4567_89AB_CDEF -> ack 1 clock after sample, held until stb low.
  - Read same address -> ack 2 clocks after sample, dat_o=64'h0123_4567_89AB_CDEF.
- Byte lanes:
  - Preload word 5 with 64'hFFFF_FFFF_FFFF_FFFF, then write sel=8'h0F, dat=0.
  - Readback = 64'hFFFF_FFFF_0000_0000. A write with sel=8'h00 leaves the word unchanged.
- Copper-style double fetch:
  - cyc held high, two reads at BASE+0 and BASE+8 with stb dropped between them.
  - Exactly two ack pulses; ack falls on the first edge with stb=0; dat_o matches each word.
- Out of range: read adr=BASE+32'h2000 -> err_o high next edge, ack_o stays 0, dat_o unchanged.
- Abort:
  - RD_LAT=4; drop cyc at the 2nd clock of LAT -> no ack, state returns to IDLE.
  - Same abort on a write -> RAM word unchanged.
- Reset: assert rst_ni low while ack_o=1 -> ack_o, err_o and dat_o go to 0 asynchronously; the next request is serviced normally after release.
